// File: rtl/enemy_update_scheduler.sv
// rtl/enemy_update_scheduler.sv - per-tick erase/update/redraw sequencer for enemy sprites (optional watchdog: ENEMY_SCHED_TIMEOUT_EN)
module enemy_update_scheduler #(
    parameter int          N_ENEMY   = 2,
    parameter int          SPRITE_W  = 4,
    parameter int          SPRITE_H  = 4,
    parameter logic [2:0]  BG_COLOUR = 3'b000,
    parameter logic [19:0] TIMEOUT   = 20'd500000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   space_pressed,
    output logic [N_ENEMY-1:0]     update_req,
    input  logic [N_ENEMY-1:0]     update_done,
    input  logic [8*N_ENEMY-1:0]   enemy_x,
    input  logic [7*N_ENEMY-1:0]   enemy_y,
    input  logic [3*N_ENEMY-1:0]   enemy_colour,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   plot,
    output logic                   frame_done,
    output logic                   busy
`ifdef ENEMY_SCHED_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    localparam int SW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(N_ENEMY - 1);
    localparam logic [4:0]    DX_LAST   = 5'(SPRITE_W - 1);
    localparam logic [4:0]    DY_LAST   = 5'(SPRITE_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_ERASE, S_UPDATE, S_DRAW, S_NEXT
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [4:0]           dx_q, dx_d, dy_q, dy_d;
    logic [7:0]           old_x_q, old_x_d, new_x_q, new_x_d;
    logic [6:0]           old_y_q, old_y_d, new_y_q, new_y_d;
    logic [N_ENEMY-1:0]   update_req_q, update_req_d;
    logic [7:0]           vga_x_q, vga_x_d;
    logic [6:0]           vga_y_q, vga_y_d;
    logic [2:0]           vga_colour_q, vga_colour_d;
    logic                 plot_q, plot_d;
    logic                 frame_done_q, frame_done_d;
`ifdef ENEMY_SCHED_TIMEOUT_EN
    logic [19:0]          wd_q, wd_d;
    logic                 timeout_err_q, timeout_err_d;
`endif

    // Current slot's bus fields and the sweep pixel address in widened arithmetic
    logic [7:0]  cur_x;
    logic [6:0]  cur_y;
    logic [2:0]  cur_colour;
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic        pix_visible, sweep_last;

    // Slot field selection and clipping of the pixel under the sweep counter
    always_comb begin
        cur_x       = enemy_x[{slot_q, 3'b000} +: 8];
        cur_y       = enemy_y[int'(slot_q) * 7 +: 7];
        cur_colour  = enemy_colour[int'(slot_q) * 3 +: 3];
        base_x      = (state_q == S_DRAW) ? new_x_q : old_x_q;
        base_y      = (state_q == S_DRAW) ? new_y_q : old_y_q;
        pix_x       = {1'b0, base_x} + {4'b0000, dx_q};
        pix_y       = {1'b0, base_y} + {3'b000, dy_q};
        pix_visible = (pix_x <= 9'd159) && (pix_y <= 8'd119);
        sweep_last  = (dx_q == DX_LAST) && (dy_q == DY_LAST);
    end

    // Next-state and registered-output logic; space_pressed overrides everything
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        old_x_d      = old_x_q;
        old_y_d      = old_y_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        update_req_d = update_req_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        plot_d       = 1'b0;
        frame_done_d = 1'b0;
`ifdef ENEMY_SCHED_TIMEOUT_EN
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LATCH;
            end
            S_LATCH: begin
                old_x_d = cur_x;
                old_y_d = cur_y;
                dx_d    = '0;
                dy_d    = '0;
                state_d = S_ERASE;
            end
            S_ERASE, S_DRAW: begin
                if (pix_visible) begin
                    plot_d       = 1'b1;
                    vga_x_d      = pix_x[7:0];
                    vga_y_d      = pix_y[6:0];
                    vga_colour_d = (state_q == S_DRAW) ? cur_colour : BG_COLOUR;
                end
                if (dx_q == DX_LAST) begin
                    dx_d = '0;
                    dy_d = dy_q + 5'd1;
                end else begin
                    dx_d = dx_q + 5'd1;
                end
                if (sweep_last) begin
                    dx_d = '0;
                    dy_d = '0;
                    if (state_q == S_ERASE) begin
                        state_d              = S_UPDATE;
                        update_req_d         = '0;
                        update_req_d[slot_q] = 1'b1;
`ifdef ENEMY_SCHED_TIMEOUT_EN
                        wd_d = '0;
`endif
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_UPDATE: begin
                if (update_req_q[slot_q] && update_done[slot_q]) begin
                    new_x_d      = cur_x;
                    new_y_d      = cur_y;
                    update_req_d = '0;
                    state_d      = S_DRAW;
                end
`ifdef ENEMY_SCHED_TIMEOUT_EN
                else if (wd_q == TIMEOUT - 20'd1) begin
                    new_x_d       = old_x_q;
                    new_y_d       = old_y_q;
                    update_req_d  = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_DRAW;
                end else begin
                    wd_d = wd_q + 20'd1;
                end
`endif
            end
            S_NEXT: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d       = '0;
                    frame_done_d = 1'b1;
                    state_d      = start ? S_LATCH : S_IDLE;
                end else begin
                    slot_d  = slot_q + SW'(1);
                    state_d = S_LATCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (space_pressed) begin
            state_d      = S_IDLE;
            slot_d       = '0;
            dx_d         = '0;
            dy_d         = '0;
            update_req_d = '0;
            plot_d       = 1'b0;
            frame_done_d = 1'b0;
`ifdef ENEMY_SCHED_TIMEOUT_EN
            wd_d          = '0;
            timeout_err_d = 1'b0;
`endif
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            old_x_q      <= '0;
            old_y_q      <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            update_req_q <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            plot_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef ENEMY_SCHED_TIMEOUT_EN
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            update_req_q <= update_req_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
            frame_done_q <= frame_done_d;
`ifdef ENEMY_SCHED_TIMEOUT_EN
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign update_req = update_req_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign plot       = plot_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_IDLE);
`ifdef ENEMY_SCHED_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_enemy_update_scheduler.sv
// tb/tb_enemy_update_scheduler.sv - directed self-checking bench for enemy_update_scheduler
module tb_enemy_update_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        space_pressed = 1'b0;
    logic [1:0]  update_req;
    logic [1:0]  update_done = 2'b00;
    logic [15:0] enemy_x = '0;
    logic [13:0] enemy_y = '0;
    logic [5:0]  enemy_colour = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        frame_done;
    logic        busy;
`ifdef ENEMY_SCHED_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    enemy_update_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .space_pressed(space_pressed),
        .update_req   (update_req),
        .update_done  (update_done),
        .enemy_x      (enemy_x),
        .enemy_y      (enemy_y),
        .enemy_colour (enemy_colour),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .plot         (plot),
        .frame_done   (frame_done),
        .busy         (busy)
`ifdef ENEMY_SCHED_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks n pixels of a 4x4 sweep, checking each registered pixel against the clip model
    task automatic sweep(input string tag, input int bx, input int by, input logic [2:0] col, input int n);
        for (int p = 0; p < n; p++) begin
            int ex;
            int ey;
            ex = bx + (p % 4);
            ey = by + (p / 4);
            tick();
            if (ex <= 159 && ey <= 119) begin
                check({tag, "_plot"}, 32'(plot), 32'd1);
                check({tag, "_x"}, 32'(vga_x), 32'(ex));
                check({tag, "_y"}, 32'(vga_y), 32'(ey));
                check({tag, "_col"}, 32'(vga_colour), 32'(col));
            end else begin
                check({tag, "_clip"}, 32'(plot), 32'd0);
            end
            if (p < 15) check({tag, "_noreq"}, 32'(update_req), 32'd0);
        end
    endtask

    // Holds done off for 'delay' request cycles, then returns new coordinates with a done pulse
    task automatic serve(input string tag, input int slot, input int delay, input int nx, input int ny,
                         input bit stray);
        logic [1:0] onehot;
        onehot = 2'b01 << slot;
        for (int c = 0; c <= delay; c++) begin
            check({tag, "_req"}, 32'(update_req), 32'(onehot));
            update_done = 2'b00;
            if (stray && c == 1) update_done = ~onehot;
            if (c == delay) begin
                enemy_x[slot*8 +: 8] = 8'(nx);
                enemy_y[slot*7 +: 7] = 7'(ny);
                update_done = onehot;
            end
            tick();
        end
        update_done = 2'b00;
        check({tag, "_reqdrop"}, 32'(update_req), 32'd0);
        check({tag, "_drawentry"}, 32'(plot), 32'd0);
    endtask

    initial begin
        enemy_x[7:0]    = 8'd120;
        enemy_y[6:0]    = 7'd35;
        enemy_colour[2:0] = 3'b101;
        enemy_x[15:8]   = 8'd10;
        enemy_y[13:7]   = 7'd20;
        enemy_colour[5:3] = 3'b011;

        #12;
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(update_req), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_vx", 32'(vga_x), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        start = 1'b1;
        tick();
        check("latch_busy", 32'(busy), 32'd1);
        check("latch_plot", 32'(plot), 32'd0);
        tick();
        check("erase0_entry", 32'(plot), 32'd0);
        sweep("f1s0_erase", 120, 35, 3'b000, 16);
        serve("f1s0_upd", 0, 3, 119, 35, 1'b1);
        sweep("f1s0_draw", 119, 35, 3'b101, 16);
        check("f1s0_nofd", 32'(frame_done), 32'd0);
        tick();
        check("f1s1_latch_fd", 32'(frame_done), 32'd0);
        check("f1s1_busy", 32'(busy), 32'd1);
        tick();
        sweep("f1s1_erase", 10, 20, 3'b000, 16);
        serve("f1s1_upd", 1, 1, 11, 21, 1'b0);
        sweep("f1s1_draw", 11, 21, 3'b011, 16);
        check("f1_next_fd", 32'(frame_done), 32'd0);
        tick();
        check("f1_fd_pulse", 32'(frame_done), 32'd1);
        check("f2_latch_busy", 32'(busy), 32'd1);
        enemy_x[7:0] = 8'd158;
        enemy_y[6:0] = 7'd35;
        tick();
        check("f1_fd_clear", 32'(frame_done), 32'd0);
        check("f2_erase_entry", 32'(plot), 32'd0);
        sweep("f2s0_erase_clip", 158, 35, 3'b000, 16);
        serve("f2s0_upd", 0, 2, 100, 50, 1'b0);
        sweep("f2s0_draw", 100, 50, 3'b101, 5);

        space_pressed = 1'b1;
        tick();
        space_pressed = 1'b0;
        check("abort_plot", 32'(plot), 32'd0);
        check("abort_req", 32'(update_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fd", 32'(frame_done), 32'd0);
        tick();
        check("restart_busy", 32'(busy), 32'd1);
        tick();
        sweep("restart_slot0", 100, 50, 3'b000, 3);

        #2;
        reset = 1'b0;
        #1;
        check("async_rst_plot", 32'(plot), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_vx", 32'(vga_x), 32'd0);
        check("async_rst_req", 32'(update_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enemy_update_scheduler.md
Name: enemy_update_scheduler

Overview:
- Sequences the per-enemy movement datapaths and the VGA pixel writer once per game tick.
- For each enemy slot in turn, it erases the sprite at its old position, requests one movement update, then redraws the sprite at the new position.
- Sits between the game-level control FSM and the enemy datapaths, and owns the shared plot bus into the VGA adapter.

Parameters:
- N_ENEMY, 2, number of enemy datapaths served (1..8)
- SPRITE_W, 4, sprite width in pixels (1..16)
- SPRITE_H, 4, sprite height in pixels (1..16)
- BG_COLOUR, 3'b000, colour used for erase
- TIMEOUT, 20'd500000, update watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; while high, frames run back to back
- space_pressed  in  1  synchronous restart/abort
- update_req  out  N_ENEMY  one-hot level request to enemy i (UpdateEnemy)
- update_done  in  N_ENEMY  done pulses from the datapaths
- enemy_x  in  8*N_ENEMY  packed x positions, slot i at [8i+7:8i]
- enemy_y  in  7*N_ENEMY  packed y positions
- enemy_colour  in  3*N_ENEMY  packed sprite colours
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- frame_done  out  1  one-cycle pulse after the last slot completes
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, slot index=0, pixel counters=0.
  - All outputs 0.
- States: IDLE, LATCH, ERASE, UPDATE, DRAW, NEXT.
- IDLE -> LATCH when start=1.
- LATCH (1 cycle): capture old_x/old_y = enemy_x[i]/enemy_y[i]; clear dx, dy.
- ERASE:
  - One pixel per cycle, row-major order (dx fastest), at (old_x+dx, old_y+dy) with BG_COLOUR.
  - Exactly SPRITE_W*SPRITE_H cycles, then go to UPDATE.
- UPDATE:
  - update_req[i]=1 from the first UPDATE cycle.
  - update_done[i] is sampled only while update_req[i] is already high; update_done bits of other slots are ignored.
  - In the cycle update_done[i]=1: capture new_x/new_y from the bus. Next cycle: update_req=0, state=DRAW, dx=dy=0.
- DRAW: same sweep as ERASE, at (new_x+dx, new_y+dy) using enemy_colour[i].
- NEXT (1 cycle):
  - If i < N_ENEMY-1: i+1, go to LATCH.
  - Otherwise: i=0, pulse frame_done. Go to LATCH if start=1, else IDLE.
  - start is sampled only in IDLE and NEXT; dropping it mid-frame finishes the frame.
- Pixel outputs:
  - vga_x, vga_y, vga_colour and plot are registered; the first pixel appears the cycle after ERASE/DRAW entry.
  - plot=0 in all other states.
- Coordinate arithmetic:
  - Sum computed in 9 bits (x) and 8 bits (y).
  - Pixels with x>159 or y>119 are clipped: plot=0 and vga_x/y hold, but the counter still advances, so sweep length is fixed.
- space_pressed=1 (synchronous, any state):
  - Next cycle: state=IDLE, i=0, update_req=0, plot=0, no frame_done.
  - Overrides a simultaneous update_done.
- Reset mid-sweep: all outputs clear immediately (asynchronous).
- busy=1 in every state except IDLE.

Optional Feature:
- Macro ENEMY_SCHED_TIMEOUT_EN.
- Defined:
  - A 20-bit watchdog counts UPDATE cycles.
  - On reaching TIMEOUT without update_done[i]: drop update_req, set sticky output timeout_err (1 bit, cleared only by reset or space_pressed), and go to DRAW using the old coordinates.
- Undefined: UPDATE waits indefinitely; no watchdog logic and no timeout_err port.

Test Plan:
- Reset, then start=1, N_ENEMY=2, enemy0 at (120,35); stub asserts done 3 cycles after req with x=119 -> 16 erase plots at x 120..123, y 35..38, colour 000; update_req=01 for 4 cycles; 16 draw plots at x 119..122 with enemy_colour[0].
- Both slots complete -> exactly one frame_done pulse after slot 1's DRAW. With start=1 held, LATCH of slot 0 follows the next cycle.
- enemy0 at x=158 -> per row, only dx=0,1 plot (x 158,159); dx=2,3 clipped; still 16 cycles in ERASE.
- update_done[1] pulsed while serving slot 0 -> ignored; req stays 01 until update_done[0].
- space_pressed asserted mid-DRAW -> next cycle plot=0, update_req=0, busy=0, i=0; no frame_done.
- With ENEMY_SCHED_TIMEOUT_EN and TIMEOUT=100, done never arrives -> req drops after 100 UPDATE cycles, timeout_err=1, redraw at old position.
